rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: waits for all channels idle (or a timeout), holds every channel in reset
// for PULSE_W cycles, then releases channel k STAGGER*k cycles after channel 0 and pulses done.
module rst_seq_ctrl #(
   parameter int N_CH    = 4,
   parameter int PULSE_W = 10,
   parameter int STAGGER = 2,
   parameter int IDLE_TO = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_i,
   input  logic [N_CH-1:0] idle_i,
   output logic [N_CH-1:0] ch_rst_n_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            timeout_o
);

   localparam int CNT_MAX = (PULSE_W > STAGGER) ? PULSE_W : STAGGER;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int TW      = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
   localparam int IW      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam bit TO_EN   = (IDLE_TO != 0);

   localparam logic [CW-1:0] PW_LAST  = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] STG_LAST = CW'((STAGGER > 0) ? STAGGER - 1 : 0);
   localparam logic [TW-1:0] TO_LAST  = TW'((IDLE_TO > 0) ? IDLE_TO - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_ASSERT,
      S_RELEASE,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic              pending_q, pending_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [N_CH-1:0]   ch_rst_n_q, ch_rst_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic              all_idle;
   logic              wait_met;
   logic [IW-1:0]     idx_nxt;

   assign all_idle = &idle_i;
   assign idx_nxt  = idx_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      cnt_d      = cnt_q;
      to_cnt_d   = to_cnt_q;
      idx_d      = idx_q;
      ch_rst_n_d = ch_rst_n_q;
      done_d     = 1'b0;
      timeout_d  = timeout_q;
      wait_met   = 1'b0;

      // Requests arriving mid-sequence collapse into a single follow-up sequence.
      if (req_i && (state_q != S_IDLE)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (req_i || pending_q) begin
               state_d   = S_WAIT_IDLE;
               pending_d = 1'b0;
               to_cnt_d  = '0;
            end
         end
         S_WAIT_IDLE: begin
            wait_met = all_idle || (TO_EN && (to_cnt_q == TO_LAST));
            if (wait_met) begin
               state_d    = S_ASSERT;
               cnt_d      = '0;
               ch_rst_n_d = '0;
               if (!all_idle) begin
                  timeout_d = 1'b1;
               end
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_ASSERT: begin
            if (cnt_q == PW_LAST) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
               if (STAGGER == 0) begin
                  ch_rst_n_d = '1;
                  idx_d      = IDX_LAST;
               end else begin
                  ch_rst_n_d    = '0;
                  ch_rst_n_d[0] = 1'b1;
                  idx_d         = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RELEASE: begin
            // idx_q is the most recently released channel; cnt_q counts cycles since that release.
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == STG_LAST) begin
               ch_rst_n_d[idx_nxt] = 1'b1;
               idx_d               = idx_nxt;
               cnt_d               = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE) || pending_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pending_q  <= 1'b1;
         cnt_q      <= '0;
         to_cnt_q   <= '0;
         idx_q      <= '0;
         ch_rst_n_q <= '1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         cnt_q      <= cnt_d;
         to_cnt_q   <= to_cnt_d;
         idx_q      <= idx_d;
         ch_rst_n_q <= ch_rst_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   assign ch_rst_n_o = ch_rst_n_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench: default-parameter sequencer plus a STAGGER=0 / no-timeout instance.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, req_i, busy_o, done_o, timeout_o;
   logic [3:0] idle_i, ch_rst_n_o;
   logic       rst_b, req_b, busy_b, done_b, to_b;
   logic [3:0] idle_b, ch_b;

   int n_cmp = 0;
   int n_err = 0;

   rst_seq_ctrl #(.N_CH(4), .PULSE_W(10), .STAGGER(2), .IDLE_TO(16)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .idle_i(idle_i),
      .ch_rst_n_o(ch_rst_n_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
   );

   rst_seq_ctrl #(.N_CH(4), .PULSE_W(10), .STAGGER(0), .IDLE_TO(0)) dut_b (
      .clk(clk), .rst(rst_b), .req_i(req_b), .idle_i(idle_b),
      .ch_rst_n_o(ch_b), .busy_o(busy_b), .done_o(done_b), .timeout_o(to_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Channel reset vector rel cycles after the wait condition is met (PULSE_W=10, STAGGER=2).
   function automatic logic [3:0] exp_ch(input int rel);
      if (rel <= 0)  return 4'hF;
      if (rel <= 10) return 4'h0;
      if (rel <= 12) return 4'h1;
      if (rel <= 14) return 4'h3;
      if (rel <= 16) return 4'h7;
      return 4'hF;
   endfunction

   // Entered just after the edge that moved the FSM into WAIT_IDLE (k=0); t is the
   // WAIT_IDLE cycle in which the wait condition is met. Ends on the cycle after done.
   task automatic check_seq(input string tag, input int t, input logic to_pre, input logic to_post,
                            input logic busy_after, input int drop_at, input int r1, input int r2);
      for (int k = 0; k <= t + 19; k++) begin
         int rel;
         if (k > 0) tick();
         rel = k - t;
         chk({tag, "/ch"},   32'(ch_rst_n_o), 32'(exp_ch(rel)));
         chk({tag, "/done"}, 32'(done_o),     32'(rel == 18));
         chk({tag, "/busy"}, 32'(busy_o),     32'((rel <= 18) ? 1'b1 : busy_after));
         chk({tag, "/to"},   32'(timeout_o),  32'((rel >= 1) ? to_post : to_pre));
         req_i = (k == r1) || (k == r2);
         if (k == drop_at) idle_i = 4'h0;
      end
      req_i = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      rst_b  = 1'b1;
      req_i  = 1'b0;
      req_b  = 1'b0;
      idle_i = 4'hF;
      idle_b = 4'h0;
      repeat (3) tick();
      chk("rst/ch",     32'(ch_rst_n_o), 32'hF);
      chk("rst/busy",   32'(busy_o),     32'h0);
      chk("rst/done",   32'(done_o),     32'h0);
      chk("rst/to",     32'(timeout_o),  32'h0);
      chk("rst_b/ch",   32'(ch_b),       32'hF);
      chk("rst_b/busy", 32'(busy_b),     32'h0);

      // Power-on sequence, all channels idle.
      rst = 1'b0;
      tick();
      check_seq("pwr", 0, 1'b0, 1'b0, 1'b0, -1, -1, -1);

      // One channel never idles: proceeds after 16 WAIT_IDLE cycles with timeout flagged.
      idle_i = 4'h7;
      req_i  = 1'b1;
      tick();
      req_i  = 1'b0;
      check_seq("tmo", 15, 1'b0, 1'b1, 1'b0, -1, -1, -1);

      // Clean sequence afterwards: timeout stays set.
      idle_i = 4'hF;
      req_i  = 1'b1;
      tick();
      req_i  = 1'b0;
      check_seq("stky", 0, 1'b1, 1'b1, 1'b0, -1, -1, -1);

      // Requests during ASSERT and RELEASE merge into exactly one follow-up sequence.
      req_i = 1'b1;
      tick();
      req_i = 1'b0;
      check_seq("mrg1", 0, 1'b1, 1'b1, 1'b1, -1, 5, 14);
      tick();
      check_seq("mrg2", 0, 1'b1, 1'b1, 1'b0, -1, -1, -1);

      // Idle dropping mid-ASSERT does not disturb the pulse or release schedule.
      req_i = 1'b1;
      tick();
      req_i = 1'b0;
      check_seq("drop", 0, 1'b1, 1'b1, 1'b0, 5, -1, -1);
      idle_i = 4'hF;

      // Reset in the cycle channel 1 releases.
      req_i = 1'b1;
      tick();
      req_i = 1'b0;
      for (int k = 1; k <= 13; k++) tick();
      chk("mid/ch_pre", 32'(ch_rst_n_o), 32'h3);
      rst = 1'b1;
      tick();
      chk("mid/ch",   32'(ch_rst_n_o), 32'hF);
      chk("mid/busy", 32'(busy_o),     32'h0);
      chk("mid/done", 32'(done_o),     32'h0);
      chk("mid/to",   32'(timeout_o),  32'h0);
      rst = 1'b0;
      tick();
      check_seq("rerun", 0, 1'b0, 1'b0, 1'b0, -1, -1, -1);

      // No stagger, no timeout: waits on idle indefinitely, then releases all at once.
      rst_b = 1'b0;
      tick();
      for (int k = 0; k < 40; k++) begin
         tick();
         chk("nto/ch_wait",   32'(ch_b),   32'hF);
         chk("nto/busy_wait", 32'(busy_b), 32'h1);
      end
      idle_b = 4'hF;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("nto/ch",   32'(ch_b),   (k <= 10) ? 32'h0 : 32'hF);
         chk("nto/done", 32'(done_b), 32'(k == 12));
      end
      chk("nto/to", 32'(to_b), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
